time_display_scan: RTL and testbench
====================================

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter SCAN_DIV, default 1000: Clk_scan cycles per digit slot; legal range 2..65535.
REQ-002 Clk_scan  input  1: single clock; all state updates on its rising edge.
REQ-003 reset  input  1: synchronous, active-low reset; sampled on the rising edge of Clk_scan.
REQ-004 seconds  input  6: binary seconds from the digital clock, 0..59 legal.
REQ-005 minutes  input  6: binary minutes, 0..59 legal.
REQ-006 hours  input  6: binary hours, 0..23 legal.
REQ-007 display_hold  input  1: 1 = freeze the snapshot; 0 = normal refresh.
REQ-008 digit_an  output  6: active-low one-hot digit enable; bit0 = seconds ones ... bit5 = hours tens.
REQ-009 seg  output  7: active-low segments {g,f,e,d,c,b,a}.
REQ-010 dp  output  1: active-low decimal point, used as the colon indicator.

Function
REQ-011 Prescaler cnt counts 0..SCAN_DIV-1 and wraps; on wrap, digit index idx advances 0->1->...->5->0.
REQ-012 Snapshot registers load seconds/minutes/hours on the cycle cnt==0 && idx==0, unless display_hold==1.
REQ-013 Blanking: when cnt==0, digit_an<=6'b111111, seg<=7'h7F, dp<=1 (anti-ghosting slot).
REQ-014 When cnt>=1: digit_an<=~(1<<idx); seg<=pattern for the snapshot digit selected by idx; all outputs registered (1-cycle latency from cnt/idx).
REQ-015 Each field is split into tens = value/10 and ones = value%10, computed from the 6-bit snapshot.
REQ-016 Out-of-range field (seconds or minutes >59, hours >23): both digits of that field show a dash (seg=7'b0111111); other fields are unaffected.
REQ-017 Digit patterns 0-9 use the standard active-low 7-segment encoding (0=7'b1000000, 1=7'b1111001, 8=7'b0000000).
REQ-018 dp is low (lit) on idx 2 and idx 4 when snapshot seconds bit0==0; otherwise it is high.
REQ-019 Exactly one digit_an bit is low in any non-blank cycle; no two bits are ever low simultaneously.
REQ-020 Changing display_hold mid-frame takes effect at the next cnt==0 && idx==0 only.

Reset
REQ-021 While reset==0: cnt=0, idx=0, snapshot=0, digit_an=6'b111111, seg=7'h7F, dp=1.
REQ-022 Reset asserted mid-frame returns all state to REQ-021 values on the next edge; the first cycle after release is a snapshot cycle (cnt==0, idx==0).

Configuration
REQ-023 Macro BLANK_LEADING_ZERO_EN defined: the hours tens digit shows blank (seg=7'h7F, anode still enabled) when its value is 0; undefined: it shows "0".
REQ-024 A dash (REQ-016) takes priority over leading-zero blanking.

Structure
REQ-025 Shared package time_disp_pkg holds the digit-index constants (IDX_SEC_ONES..IDX_HR_TENS), the SEG_BLANK and SEG_DASH constants, and the 0-9 segment lookup.
REQ-026 One sub-module bin2bcd_6b (combinational 6-bit to tens/ones, plus an out-of-range flag against a max input), instantiated three times.

Verification
REQ-027 SCAN_DIV=4; reset low for 2 cycles, then release -> outputs stay blank for 1 cycle, then digit_an=6'b111110 for 3 cycles, then a blank cycle, then 6'b111101.
REQ-028 hours=12, minutes=34, seconds=56 -> per slot seg shows 6,5,4,3,2,1 for idx 0..5; dp low on idx 2 and 4.
REQ-029 seconds=57 -> dp stays high on all digits for the whole frame.
REQ-030 minutes=60 -> idx 2 and 3 show 7'b0111111; the seconds and hours digits are correct.
REQ-031 display_hold=1, then the inputs change from 01:02:03 to 04:05:06 -> the frames keep showing 01:02:03; after display_hold=0 the next full frame shows 04:05:06.
REQ-032 hours=5, with and without BLANK_LEADING_ZERO_EN -> idx 5 seg=7'h7F versus 7'b1000000; a reset mid-frame blanks all outputs on the next edge.

Source files
------------

// File: rtl/time_disp_pkg.sv
// rtl/time_disp_pkg.sv - shared digit-index constants and 7-segment lookup for time_display_scan
package time_disp_pkg;

  localparam logic [2:0] IDX_SEC_ONES = 3'd0;
  localparam logic [2:0] IDX_SEC_TENS = 3'd1;
  localparam logic [2:0] IDX_MIN_ONES = 3'd2;
  localparam logic [2:0] IDX_MIN_TENS = 3'd3;
  localparam logic [2:0] IDX_HR_ONES  = 3'd4;
  localparam logic [2:0] IDX_HR_TENS  = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 never reach here but render blank.
  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_of_digit = 7'b1000000;
      4'd1:    seg_of_digit = 7'b1111001;
      4'd2:    seg_of_digit = 7'b0100100;
      4'd3:    seg_of_digit = 7'b0110000;
      4'd4:    seg_of_digit = 7'b0011001;
      4'd5:    seg_of_digit = 7'b0010010;
      4'd6:    seg_of_digit = 7'b0000010;
      4'd7:    seg_of_digit = 7'b1111000;
      4'd8:    seg_of_digit = 7'b0000000;
      4'd9:    seg_of_digit = 7'b0010000;
      default: seg_of_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd_6b.sv
// rtl/time_display_scan_bin2bcd_6b.sv - combinational 6-bit binary to tens/ones split with range flag
module bin2bcd_6b (
  input  logic [5:0] value,
  input  logic [5:0] max_value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       out_of_range
);

  always_comb begin
    tens         = 4'(value / 6'd10);
    ones         = 4'(value % 6'd10);
    out_of_range = (value > max_value);
  end

endmodule

// File: rtl/time_display_scan.sv
// rtl/time_display_scan.sv - six-digit multiplexed HH:MM:SS scanner; BLANK_LEADING_ZERO_EN blanks a zero hours-tens digit
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       Clk_scan,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [5:0] hours,
  input  logic       display_hold,
  output logic [5:0] digit_an,
  output logic [6:0] seg,
  output logic       dp
);

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit LZ_BLANK = 1'b1;
`else
  localparam bit LZ_BLANK = 1'b0;
`endif

  localparam logic [15:0] CNT_MAX = 16'(SCAN_DIV - 1);

  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [5:0]  snap_sec, snap_min, snap_hr;

  logic [3:0] sec_tens, sec_ones, min_tens, min_ones, hr_tens, hr_ones;
  logic       sec_oor, min_oor, hr_oor;

  logic [3:0] digit;
  logic       dash;
  logic       lz_blank;
  logic [5:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  bin2bcd_6b u_sec (.value(snap_sec), .max_value(6'd59), .tens(sec_tens), .ones(sec_ones), .out_of_range(sec_oor));
  bin2bcd_6b u_min (.value(snap_min), .max_value(6'd59), .tens(min_tens), .ones(min_ones), .out_of_range(min_oor));
  bin2bcd_6b u_hr  (.value(snap_hr),  .max_value(6'd23), .tens(hr_tens),  .ones(hr_ones),  .out_of_range(hr_oor));

  always_comb begin
    digit    = 4'd0;
    dash     = 1'b0;
    lz_blank = 1'b0;
    case (idx)
      IDX_SEC_ONES: begin digit = sec_ones; dash = sec_oor; end
      IDX_SEC_TENS: begin digit = sec_tens; dash = sec_oor; end
      IDX_MIN_ONES: begin digit = min_ones; dash = min_oor; end
      IDX_MIN_TENS: begin digit = min_tens; dash = min_oor; end
      IDX_HR_ONES:  begin digit = hr_ones;  dash = hr_oor;  end
      IDX_HR_TENS: begin
        digit    = hr_tens;
        dash     = hr_oor;
        lz_blank = LZ_BLANK && (hr_tens == 4'd0);
      end
      default: ;
    endcase

    // Dash wins over leading-zero blanking so a bad hours value is always visible.
    if (dash)
      seg_next = SEG_DASH;
    else if (lz_blank)
      seg_next = SEG_BLANK;
    else
      seg_next = seg_of_digit(digit);

    an_next = ~(6'b000001 << idx);
    dp_next = ~(((idx == IDX_MIN_ONES) || (idx == IDX_HR_ONES)) && !snap_sec[0]);
  end

  always_ff @(posedge Clk_scan) begin
    if (!reset) begin
      cnt      <= '0;
      idx      <= IDX_SEC_ONES;
      snap_sec <= '0;
      snap_min <= '0;
      snap_hr  <= '0;
      digit_an <= 6'b111111;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= (idx == IDX_HR_TENS) ? IDX_SEC_ONES : idx + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end

      if ((cnt == 16'd0) && (idx == IDX_SEC_ONES) && !display_hold) begin
        snap_sec <= seconds;
        snap_min <= minutes;
        snap_hr  <= hours;
      end

      // Slot start is a dark cycle so the previous digit's segments never ghost onto the next anode.
      if (cnt == 16'd0) begin
        digit_an <= 6'b111111;
        seg      <= SEG_BLANK;
        dp       <= 1'b1;
      end else begin
        digit_an <= an_next;
        seg      <= seg_next;
        dp       <= dp_next;
      end
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// tb/tb_time_display_scan.sv - self-checking bench for time_display_scan against a cycle-indexed time model
module tb_time_display_scan;

  localparam int DIV = 4;
  localparam int FRAME = DIV * 6;

`ifdef BLANK_LEADING_ZERO_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] seconds = '0, minutes = '0, hours = '0;
  logic       display_hold = 1'b0;
  logic [5:0] digit_an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_pass = 0;

  int k = 0;
  int ms_s = 0, ms_m = 0, ms_h = 0;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  time_display_scan #(.SCAN_DIV(DIV)) dut (
    .Clk_scan(clk), .reset(reset), .seconds(seconds), .minutes(minutes), .hours(hours),
    .display_hold(display_hold), .digit_an(digit_an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] model_seg(int ix);
    int v, lim, d;
    v   = (ix < 2) ? ms_s : (ix < 4) ? ms_m : ms_h;
    lim = (ix < 4) ? 59 : 23;
    if (v > lim) return 7'b0111111;
    d = (ix % 2 == 0) ? v % 10 : v / 10;
    if (ix == 5 && d == 0 && LZ) return 7'h7F;
    return seg_ref[d];
  endfunction

  task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance one edge; the frame position is derived from the cycle count since reset release.
  task automatic tick(string tag);
    int ph, ix;
    logic [5:0] e_an;
    logic [6:0] e_seg;
    logic e_dp;
    @(posedge clk);
    #1;
    e_an = 6'b111111; e_seg = 7'h7F; e_dp = 1'b1;
    if (!reset) begin
      k = 0; ms_s = 0; ms_m = 0; ms_h = 0;
    end else begin
      ph = k % DIV;
      ix = (k / DIV) % 6;
      if (ph != 0) begin
        e_an[ix] = 1'b0;
        e_seg = model_seg(ix);
        e_dp = !((ix == 2 || ix == 4) && (ms_s % 2 == 0));
      end
      if (ph == 0 && ix == 0 && !display_hold) begin
        ms_s = seconds; ms_m = minutes; ms_h = hours;
      end
      k++;
    end
    chk({tag, ".an"}, {1'b0, digit_an}, {1'b0, e_an});
    chk({tag, ".seg"}, seg, e_seg);
    chk({tag, ".dp"}, {6'd0, dp}, {6'd0, e_dp});
  endtask

  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic set_time(int h, int m, int s);
    hours = 6'(h); minutes = 6'(m); seconds = 6'(s);
  endtask

  initial begin
    // Reset and release scan sequence
    set_time(12, 34, 56);
    reset = 1'b0;
    run("reset", 2);
    chk("reset.seg", seg, 7'h7F);
    reset = 1'b1;
    tick("rel0");
    chk("rel0.an", {1'b0, digit_an}, 7'b0111111);
    for (int i = 0; i < 3; i++) begin
      tick("rel_slot0");
      chk("rel_slot0.an", {1'b0, digit_an}, 7'b0111110);
    end
    tick("rel_blank");
    chk("rel_blank.an", {1'b0, digit_an}, 7'b0111111);
    tick("rel_slot1");
    chk("rel_slot1.an", {1'b0, digit_an}, 7'b0111101);
    chk("rel_slot1.seg", seg, 7'b0010010);
    run("t123456", FRAME * 2 - 6);

    set_time(12, 34, 57);
    run("sec57", FRAME * 2);
    set_time(12, 60, 56);
    run("min60", FRAME * 2);

    // Hold freezes the snapshot until the next frame start after release
    set_time(1, 2, 3);
    run("pre_hold", FRAME * 2);
    display_hold = 1'b1;
    run("hold_a", 7);
    set_time(4, 5, 6);
    run("hold_b", FRAME * 2);
    display_hold = 1'b0;
    run("unhold", FRAME * 2);

    set_time(5, 7, 8);
    run("hr5", FRAME * 2);

    // Mid-frame reset
    run("mid", 9);
    reset = 1'b0;
    tick("midrst");
    chk("midrst.an", {1'b0, digit_an}, 7'b0111111);
    chk("midrst.seg", seg, 7'h7F);
    reset = 1'b1;
    run("after_rst", FRAME);

    // Randomized mixes of legal/illegal times, hold and resets
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0)
        set_time($urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
      else
        set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      display_hold = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b0;
        run("rnd_rst", $urandom_range(1, 2));
        reset = 1'b1;
      end
      run("rnd", $urandom_range(1, 40));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
